// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: streams word fetches into a small FIFO
// and hands them to the decoder; a redirect flushes queue and in-flight data.
module prefetch_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [ADDR_WIDTH-1:0]    target_addr_i,
  input  logic                     target_valid_i,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDR_WIDTH-1:0]    instr_addr_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic                     imem_valid_o,
  input  logic                     imem_ready_i,
  output logic [ADDR_WIDTH-1:0]    imem_addr_o,
  output logic [DATA_WIDTH-1:0]    imem_wdata_o,
  output logic [3:0]               imem_we_o,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  output logic [$clog2(DEPTH):0]   fill_level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_C = (PW+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0] count_q;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] tgt;
  logic push, pop;
  logic [PW:0] push_w, pop_w;
  logic space_idle, space_hs;

  assign tgt = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign pop = (count_q != '0) && instr_ready_i && !target_valid_i;
  assign push = (state_q == REQ) && imem_ready_i && !target_valid_i;
  assign push_w = {{PW{1'b0}}, push};
  assign pop_w = {{PW{1'b0}}, pop};

  // space_hs accounts for the response being pushed this cycle
  assign space_idle = (count_q - pop_w) < DEPTH_C;
  assign space_hs = (count_q + ONE_C - pop_w) < DEPTH_C;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    unique case (state_q)
      IDLE: begin
        if (target_valid_i) begin
          pc_d = tgt;
        end else if (req_i && space_idle) begin
          addr_d = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (target_valid_i) begin
          pc_d = tgt;
          if (!imem_ready_i) begin
            state_d = DISCARD;
          end else if (req_i) begin
            addr_d = tgt;
          end else begin
            state_d = IDLE;
          end
        end else if (imem_ready_i) begin
          pc_d = addr_q + FOUR;
          if (req_i && space_hs) begin
            addr_d = addr_q + FOUR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (target_valid_i) begin
          pc_d = tgt;
          if (imem_ready_i) begin
            if (req_i) begin
              addr_d = tgt;
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (imem_ready_i) begin
          if (req_i) begin
            addr_d = pc_q;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_ADDR;
      addr_q <= RESET_ADDR;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      if (target_valid_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop) rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + push_w - pop_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr_q] <= imem_rdata_i;
      addr_mem[wptr_q] <= addr_q;
    end
  end

  // head is masked so outputs read zero while empty and after reset
  assign instr_valid_o = (count_q != '0);
  assign instr_o = instr_valid_o ? data_mem[rptr_q] : '0;
  assign instr_addr_o = instr_valid_o ? addr_mem[rptr_q] : '0;
  assign imem_valid_o = (state_q != IDLE);
  assign imem_addr_o = addr_q;
  assign imem_wdata_o = '0;
  assign imem_we_o = '0;
  assign fill_level_o = count_q;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: streaming, back-pressure, redirects,
// req_i drop and asynchronous reset, against hand-derived cycle expectations.
module tb_prefetch_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [31:0] tgt = '0;
  logic tgt_v = 1'b0;
  logic rdy = 1'b0;
  logic mrdy = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic instr_valid;
  logic imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0] imem_we;
  logic [31:0] imem_rdata;
  logic [2:0] fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory returns the inverted address so data and address are distinct
  assign imem_rdata = ~imem_addr;

  prefetch_buffer dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .target_addr_i(tgt),
    .target_valid_i(tgt_v),
    .instr_o(instr),
    .instr_addr_o(instr_addr),
    .instr_valid_o(instr_valid),
    .instr_ready_i(rdy),
    .imem_valid_o(imem_valid),
    .imem_ready_i(mrdy),
    .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata),
    .imem_we_o(imem_we),
    .imem_rdata_i(imem_rdata),
    .fill_level_o(fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ivalid"}, 32'(imem_valid), 32'd0);
    chk({tag, "_iaddr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_fill"}, 32'(fill), 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_iaddr_o"}, instr_addr, 32'h0);
  endtask

  initial begin
    #1;
    chk_idle_outs("rst");
    chk("wdata", imem_wdata, 32'h0);
    chk("we", 32'(imem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // streaming with zero-wait memory and an always-ready consumer
    req = 1'b1;
    mrdy = 1'b1;
    rdy = 1'b1;
    tick();
    chk("s_first_addr", imem_addr, 32'h0);
    chk("s_first_valid", 32'(imem_valid), 32'd1);
    chk("s_first_empty", 32'(instr_valid), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s_addr", imem_addr, 32'(4 * i));
      chk("s_valid", 32'(instr_valid), 32'd1);
      chk("s_head", instr_addr, 32'(4 * (i - 1)));
      chk("s_data", instr, ~32'(4 * (i - 1)));
      chk("s_fill", 32'(fill), 32'd1);
    end

    // consumer stalled: exactly four handshakes then fetch stops
    pulse_rst();
    rdy = 1'b0;
    tick();
    chk("bp_addr0", imem_addr, 32'h0);
    repeat (3) tick();
    chk("bp_addr3", imem_addr, 32'hC);
    chk("bp_fill3", 32'(fill), 32'd3);
    tick();
    chk("bp_stop", 32'(imem_valid), 32'd0);
    chk("bp_full", 32'(fill), 32'd4);
    tick();
    chk("bp_hold_valid", 32'(imem_valid), 32'd0);
    chk("bp_hold_fill", 32'(fill), 32'd4);
    chk("bp_hold_head", instr_addr, 32'h0);
    chk("bp_hold_data", instr, ~32'h0);
    rdy = 1'b1;
    tick();
    chk("bp_resume_addr", imem_addr, 32'h10);
    chk("bp_resume_valid", 32'(imem_valid), 32'd1);
    chk("bp_resume_head", instr_addr, 32'h4);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("bp_seq_head", instr_addr, 32'(4 * i));
      chk("bp_seq_fill", 32'(fill), 32'd3);
    end

    // redirect while the request at 0x8 is stalled
    pulse_rst();
    repeat (3) tick();
    chk("rd_pre_addr", imem_addr, 32'h8);
    chk("rd_pre_head", instr_addr, 32'h4);
    mrdy = 1'b0;
    tgt = 32'h103;
    tgt_v = 1'b1;
    tick();
    tgt_v = 1'b0;
    chk("rd_hold_addr", imem_addr, 32'h8);
    chk("rd_hold_valid", 32'(imem_valid), 32'd1);
    chk("rd_flush_fill", 32'(fill), 32'd0);
    chk("rd_flush_valid", 32'(instr_valid), 32'd0);
    repeat (2) tick();
    chk("rd_hold2_addr", imem_addr, 32'h8);
    mrdy = 1'b1;
    tick();
    chk("rd_new_addr", imem_addr, 32'h100);
    chk("rd_drop_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("rd_first_head", instr_addr, 32'h100);
    chk("rd_first_data", instr, ~32'h100);
    chk("rd_next_addr", imem_addr, 32'h104);

    // redirect together with a pop and a handshake, two entries buffered
    rdy = 1'b0;
    tick();
    chk("rh_fill2", 32'(fill), 32'd2);
    chk("rh_addr", imem_addr, 32'h108);
    rdy = 1'b1;
    tgt = 32'h200;
    tgt_v = 1'b1;
    tick();
    tgt_v = 1'b0;
    chk("rh_fill0", 32'(fill), 32'd0);
    chk("rh_empty", 32'(instr_valid), 32'd0);
    chk("rh_addr_tgt", imem_addr, 32'h200);
    chk("rh_req_valid", 32'(imem_valid), 32'd1);
    tick();
    chk("rh_head", instr_addr, 32'h200);
    chk("rh_fill1", 32'(fill), 32'd1);

    // req_i falls while a request is outstanding
    req = 1'b0;
    mrdy = 1'b0;
    tick();
    chk("rq_hold_addr", imem_addr, 32'h204);
    chk("rq_hold_valid", 32'(imem_valid), 32'd1);
    chk("rq_hold_fill", 32'(fill), 32'd0);
    mrdy = 1'b1;
    tick();
    chk("rq_done_valid", 32'(imem_valid), 32'd0);
    chk("rq_stored_head", instr_addr, 32'h204);
    chk("rq_stored_fill", 32'(fill), 32'd1);
    tick();
    chk("rq_idle_valid", 32'(imem_valid), 32'd0);
    chk("rq_idle_fill", 32'(fill), 32'd0);
    req = 1'b1;
    tick();
    chk("rq_resume_addr", imem_addr, 32'h208);
    chk("rq_resume_valid", 32'(imem_valid), 32'd1);

    // asynchronous reset while discarding
    mrdy = 1'b0;
    tgt = 32'h300;
    tgt_v = 1'b1;
    tick();
    tgt_v = 1'b0;
    chk("dr_valid", 32'(imem_valid), 32'd1);
    chk("dr_addr", imem_addr, 32'h208);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outs("arst");
    #1;
    rst = 1'b0;
    mrdy = 1'b1;
    tick();
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", 32'(imem_valid), 32'd1);
    tick();
    chk("ar_head", instr_addr, 32'h0);
    chk("ar_data", instr, ~32'h0);
    chk("ar_ivalid", 32'(instr_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
